lsu_mem_ctrl: RTL

//  MEM-stage load/store initiator driving the word-organised data_memory port (1-cycle registered read, lane stores per funct3).

---
 rtl/lsu_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : MEM-stage load/store initiator for a word-organised data memory
//            with a 1-cycle registered read port and funct3-encoded lane
//            stores. Accepts one request at a time, issues 1..4 memory
//            accesses, splits misaligned loads into two word reads and
//            misaligned stores into byte stores, returns extended load data
//            or a store acknowledge, and flags bad requests.
// Ports    : clk, rst                      - clock, async active-high reset
//            req_valid_i / req_ready_o     - request handshake (ready in IDLE)
//            req_write_i, req_funct3_i,
//            req_addr_i, req_wdata_i       - request fields, latched on accept
//            resp_valid_o, resp_rdata_o,
//            resp_err_o                    - one-cycle completion response
//            busy_o                        - pipeline stall while not IDLE
//            MemRead_en_o, MemWrite_en_o,
//            mem_funct3_o, mem_addr_o,
//            mem_wdata_o, mem_rdata_i      - data_memory port
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  busy_o,
  output logic                  MemRead_en_o,
  output logic                  MemWrite_en_o,
  output logic [2:0]            mem_funct3_o,
  output logic [31:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD0  = 3'd1,
    S_LD1  = 3'd2,
    S_LD2  = 3'd3,
    S_ST   = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mis_q, mis_d;     // load spans two words / store is split
  logic                  err_q, err_d;
  logic [1:0]            cnt_q, cnt_d;     // byte index of a split store
  logic [DATA_WIDTH-1:0] w0_q, w0_d;
  logic [DATA_WIDTH-1:0] w1_q, w1_d;

  // --------------------------------------------------------------------------
  // Request decode (only meaningful in the accept cycle)
  // --------------------------------------------------------------------------
  logic req_accept;
  logic req_ok;
  logic req_mis;
  logic req_err;

  assign req_accept = req_valid_i & req_ready_o;

  always_comb begin
    req_ok  = 1'b0;
    req_mis = 1'b0;
    if (req_write_i) begin
      req_ok = ~req_funct3_i[2] & (req_funct3_i[1:0] != 2'b11);
    end else begin
      req_ok = (req_funct3_i[1:0] != 2'b11) & (req_funct3_i != 3'b110);
    end
    case (req_funct3_i[1:0])
      // A half load only needs a second word when it starts on the last byte.
      2'b01:   req_mis = req_write_i ? req_addr_i[0] : (req_addr_i[1:0] == 2'b11);
      2'b10:   req_mis = (req_addr_i[1:0] != 2'b00);
      default: req_mis = 1'b0;
    endcase
  end

  assign req_err = ~req_ok | (req_mis & ~ALLOW_MISALIGNED);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic [1:0] split_last;
  assign split_last = funct3_q[1] ? 2'd3 : 2'd1;

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mis_d    = mis_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    case (state_q)
      S_IDLE: begin
        if (req_accept) begin
          write_d  = req_write_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          mis_d    = req_mis;
          err_d    = req_err;
          cnt_d    = 2'd0;
          w0_d     = '0;
          w1_d     = '0;
          if (req_err)          state_d = S_RESP;
          else if (req_write_i) state_d = S_ST;
          else                  state_d = S_LD0;
        end
      end
      S_LD0: state_d = S_LD1;
      S_LD1: begin
        w0_d = mem_rdata_i;
        if (mis_q) begin
          state_d = S_LD2;
        end else begin
          w1_d    = '0;
          state_d = S_RESP;
        end
      end
      S_LD2: begin
        w1_d    = mem_rdata_i;
        state_d = S_RESP;
      end
      S_ST: begin
        if (!mis_q || (cnt_q == split_last)) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 2'd0;
      w0_q     <= '0;
      w1_q     <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Load data alignment and extension
  // --------------------------------------------------------------------------
  logic [2*DATA_WIDTH-1:0] ld_pair;
  logic [DATA_WIDTH-1:0]   ld_word;
  logic [DATA_WIDTH-1:0]   ld_ext;

  assign ld_pair = {w1_q, w0_q} >> {addr_q[1:0], 3'b000};
  assign ld_word = ld_pair[DATA_WIDTH-1:0];

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_word[7]}}, ld_word[7:0]};
      3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_word[7:0]};
      3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_word[15]}}, ld_word[15:0]};
      3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  logic [31:0]           word_addr;
  logic [DATA_WIDTH-1:0] st_byte;

  assign word_addr = {addr_q[31:2], 2'b00};
  assign st_byte   = wdata_q >> {cnt_q, 3'b000};

  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_err_o   = (state_q == S_RESP) & err_q;
  assign resp_rdata_o = ((state_q == S_RESP) && !err_q && !write_q) ? ld_ext : '0;

  always_comb begin
    MemRead_en_o  = 1'b0;
    MemWrite_en_o = 1'b0;
    mem_funct3_o  = 3'd0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    case (state_q)
      S_LD0: begin
        MemRead_en_o = 1'b1;
        mem_addr_o   = word_addr;
      end
      S_LD1: begin
        if (mis_q) begin
          MemRead_en_o = 1'b1;
          mem_addr_o   = word_addr + 32'd4;
        end
      end
      S_ST: begin
        MemWrite_en_o = 1'b1;
        if (mis_q) begin
          mem_funct3_o = 3'b000;
          mem_addr_o   = addr_q + 32'(cnt_q);
          mem_wdata_o  = {{(DATA_WIDTH-8){1'b0}}, st_byte[7:0]};
        end else begin
          mem_funct3_o = funct3_q;
          mem_addr_o   = addr_q;
          mem_wdata_o  = wdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
